// File: rtl/fetch_prefetch_buffer.sv
// rtl/fetch_prefetch_buffer.sv - sequential instruction prefetch buffer with redirect flush
// Ports:
//   clk, rst                        core clock, asynchronous active-low reset
//   redirect, redirect_pc           flush the buffer and restart fetch at redirect_pc
//   inst_valid, inst_ready          head-entry handshake towards the core
//   inst_data, inst_pc              head instruction word and its address (0 when empty)
//   mem_req, mem_addr               single-outstanding read request to instruction memory
//   mem_rvalid, mem_rdata           read response (one-cycle pulse)
//   level                           current FIFO occupancy
module fetch_prefetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   input  logic                     inst_ready,
   output logic                     inst_valid,
   output logic [31:0]              inst_data,
   output logic [31:0]              inst_pc,
   output logic                     mem_req,
   output logic [31:0]              mem_addr,
   input  logic                     mem_rvalid,
   input  logic [31:0]              mem_rdata,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int               PTR_W = $clog2(DEPTH);
   localparam int               CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [31:0]      fpc;
   logic [31:0]      pc_mem   [DEPTH];
   logic [31:0]      data_mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (mem_req) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A redirect while the response is still out must swallow that stale word.
            if (mem_rvalid) begin
               state_nxt = ST_IDLE;
            end else if (redirect) begin
               state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // The stale word is dropped whenever it arrives; a further redirect only moves fpc.
            if (mem_rvalid) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      mem_req = (state == ST_IDLE) && (count < FULL) && !redirect;
   end

   assign push = (state == ST_WAIT) && mem_rvalid && !redirect;
   assign pop  = (count != '0) && inst_ready && !redirect;

   // ---------------- fetch PC, pointers and occupancy ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpc    <= RESET_PC;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         fpc    <= redirect_pc;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fpc    <= fpc + PC_STEP;
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: contents are masked by count on the outputs.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= fpc;
         data_mem[wr_ptr] <= mem_rdata;
      end
   end

   assign inst_valid = (count != '0);
   assign inst_data  = inst_valid ? data_mem[rd_ptr] : 32'h0;
   assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : 32'h0;
   assign mem_addr   = fpc;
   assign level      = count;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb/tb_fetch_prefetch_buffer.sv - self-checking bench for fetch_prefetch_buffer
module tb_fetch_prefetch_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_ready;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [2:0]  level;

   always #5 clk = ~clk;

   fetch_prefetch_buffer #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000),
      .PC_STEP  (32'd4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_ready  (inst_ready),
      .inst_valid  (inst_valid),
      .inst_data   (inst_data),
      .inst_pc     (inst_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .level       (level)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } sb_t;

   typedef struct {
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_data;
      logic [2:0]  e_level;
   } vec_t;

   sb_t         sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          lat   = 1;
   int          pcnt  = 0;
   bit          pending = 1'b0;
   logic [31:0] paddr = 32'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock: scoreboard/memory capture just before the edge, memory response just after.
   task automatic tick();
      sb_t e;
      #1;
      if (rst) begin
         if (inst_valid && inst_ready && !redirect) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_unexpected_pop: got pc %h expected no entry", inst_pc);
            end else begin
               e = sb.pop_front();
               chk("sb_pc", inst_pc, e.pc);
               chk("sb_data", inst_data, e.data);
            end
         end
         if (redirect) sb.delete();
         if (mem_req) begin
            pending = 1'b1;
            pcnt    = lat;
            paddr   = mem_addr;
            e.pc    = mem_addr;
            e.data  = mem_addr ^ 32'hA5A5_0000;
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      if (pending) begin
         pcnt--;
         if (pcnt == 0) begin
            pending    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = paddr ^ 32'hA5A5_0000;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      inst_ready  = 1'b0;
      mem_rvalid  = 1'b0;
      mem_rdata   = 32'h0;
      pending     = 1'b0;
      sb.delete();
      @(posedge clk);
      #2;
      chk("rst_valid", 32'(inst_valid), 32'h0);
      chk("rst_level", 32'(level), 32'h0);
      chk("rst_pc", inst_pc, 32'h0);
      chk("rst_data", inst_data, 32'h0);
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt[7];
      logic [31:0] exp_pc;

      vt[0] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0,        3'd0};
      vt[1] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,        3'd0};
      vt[2] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, 32'h0, 32'hA5A5_0000, 3'd1};
      vt[3] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0,        3'd0};
      vt[4] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 32'h4, 32'hA5A5_0004, 3'd1};
      vt[5] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h8, 1'b0, 32'h0, 32'h0,        3'd0};
      vt[6] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'hC, 1'b1, 32'h8, 32'hA5A5_0008, 3'd1};

      // L=1 streaming from reset, table driven
      lat = 1;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         inst_ready  = vt[i].ready;
         redirect    = vt[i].redir;
         redirect_pc = vt[i].rpc;
         #1;
         chk($sformatf("vec%0d_req", i),   32'(mem_req),    32'(vt[i].e_req));
         chk($sformatf("vec%0d_addr", i),  mem_addr,        vt[i].e_addr);
         chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vt[i].e_valid));
         chk($sformatf("vec%0d_pc", i),    inst_pc,         vt[i].e_pc);
         chk($sformatf("vec%0d_data", i),  inst_data,       vt[i].e_data);
         chk($sformatf("vec%0d_level", i), 32'(level),      32'(vt[i].e_level));
         tick();
      end

      // Fill to DEPTH with the core stalled, then release one slot
      do_reset();
      lat = 1;
      for (int i = 0; i < 20 && level != 3'd4; i++) tick();
      chk("full_level", 32'(level), 32'd4);
      chk("full_noreq", 32'(mem_req), 32'h0);
      tick();
      tick();
      chk("full_noreq_hold", 32'(mem_req), 32'h0);
      inst_ready = 1'b1;
      #1;
      chk("full_head_pc", inst_pc, 32'h0);
      tick();
      inst_ready = 1'b0;
      #1;
      chk("after_pop_level", 32'(level), 32'd3);
      chk("after_pop_req", 32'(mem_req), 32'h1);
      chk("after_pop_addr", mem_addr, 32'd16);
      tick();

      // L=3 redirect one cycle after a request: stale word must be flushed
      do_reset();
      lat = 3;
      inst_ready = 1'b1;
      #1;
      chk("l3_first_req", 32'(mem_req), 32'h1);
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      #1;
      chk("redir_no_req", 32'(mem_req), 32'h0);
      tick();
      redirect = 1'b0;
      #1;
      chk("flush_valid", 32'(inst_valid), 32'h0);
      for (int i = 0; i < 10; i++) begin
         if (mem_rvalid) break;
         chk("flush_hold_req", 32'(mem_req), 32'h0);
         tick();
      end
      chk("flush_stale_seen", 32'(mem_rvalid), 32'h1);
      chk("flush_stale_noreq", 32'(mem_req), 32'h0);
      tick();
      chk("flush_req", 32'(mem_req), 32'h1);
      chk("flush_addr", mem_addr, 32'h100);
      chk("flush_level", 32'(level), 32'h0);
      for (int i = 0; i < 20; i++) begin
         if (inst_valid) break;
         tick();
      end
      chk("redir_first_pc", inst_pc, 32'h100);
      chk("redir_first_data", inst_data, 32'hA5A5_0100);
      tick();

      // Redirect, response and pop all in one cycle at level 2
      do_reset();
      lat = 1;
      for (int i = 0; i < 20; i++) begin
         if (level == 3'd2 && mem_rvalid) break;
         tick();
      end
      chk("trip_level", 32'(level), 32'd2);
      chk("trip_rvalid", 32'(mem_rvalid), 32'h1);
      inst_ready  = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      #1;
      chk("trip_valid_before", 32'(inst_valid), 32'h1);
      tick();
      redirect   = 1'b0;
      inst_ready = 1'b0;
      #1;
      chk("trip_level_after", 32'(level), 32'h0);
      chk("trip_valid_after", 32'(inst_valid), 32'h0);
      chk("trip_data_after", inst_data, 32'h0);
      chk("trip_req", 32'(mem_req), 32'h1);
      chk("trip_addr", mem_addr, 32'h200);
      tick();

      // Reset mid-WAIT; stale response lands in IDLE right after release
      do_reset();
      lat = 5;
      #1;
      chk("rw_req", 32'(mem_req), 32'h1);
      tick();
      rst = 1'b0;
      sb.delete();
      #1;
      chk("rw_level_in_rst", 32'(level), 32'h0);
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      #1;
      chk("rw_stale_present", 32'(mem_rvalid), 32'h1);
      chk("rw_req_after", 32'(mem_req), 32'h1);
      chk("rw_addr_after", mem_addr, 32'h0);
      chk("rw_level_after", 32'(level), 32'h0);
      tick();
      chk("rw_level_ignored", 32'(level), 32'h0);
      chk("rw_valid_ignored", 32'(inst_valid), 32'h0);
      chk("rw_wait_noreq", 32'(mem_req), 32'h0);

      // Steady state at level 2: pop only on push cycles
      do_reset();
      lat = 1;
      for (int i = 0; i < 20 && level != 3'd2; i++) tick();
      chk("ss_level_reached", 32'(level), 32'd2);
      exp_pc = 32'h0;
      for (int i = 0; i < 8; i++) begin
         inst_ready = mem_rvalid;
         #1;
         chk("ss_level", 32'(level), 32'd2);
         if (inst_ready) begin
            chk("ss_pc", inst_pc, exp_pc);
            exp_pc = exp_pc + 32'd4;
         end
         tick();
      end
      inst_ready = 1'b0;

      // Fetch PC wraps from FFFF_FFFC to 0
      do_reset();
      lat = 1;
      inst_ready  = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      #1;
      chk("wrap_req", 32'(mem_req), 32'h1);
      chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
      tick();
      tick();
      chk("wrap_next_addr", mem_addr, 32'h0);
      chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
      chk("wrap_data", inst_data, 32'h5A5A_FFFC);
      tick();
      inst_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_prefetch_buffer.md
# fetch_prefetch_buffer

- Sits between instruction memory and the `scc` core's fetch input.
- Issues sequential instruction-word reads to a variable-latency instruction memory, one request outstanding at a time.
- Buffers returned words with their PCs in a small FIFO and presents them to the core with a valid/ready handshake.
- Flushes on a branch redirect from execute and discards any stale in-flight response.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `PC_STEP`, 4: increment between sequential fetch addresses.

Ports:
- `clk`  in  1  core clock; one clock domain.
- `rst`  in  1  reset, asynchronous, active-low.
- `redirect`  in  1  branch taken in execute; flush and refetch.
- `redirect_pc`  in  32  new fetch address; valid when `redirect`=1.
- `inst_ready`  in  1  core consumes head entry.
- `inst_valid`  out  1  head entry present.
- `inst_data`  out  32  head instruction word.
- `inst_pc`  out  32  address of head instruction.
- `mem_req`  out  1  read request; memory samples on this clock edge.
- `mem_addr`  out  32  read address; always equals fetch PC.
- `mem_rvalid`  in  1  read data returned (single-cycle pulse).
- `mem_rdata`  in  32  returned word; valid with `mem_rvalid`.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation

- State: fetch PC `fpc`; FSM {IDLE, WAIT, FLUSH}; FIFO of {pc, data} with read pointer, write pointer and count.
- `mem_req` = (state==IDLE) && (count<DEPTH) && !`redirect`. This is combinational. `mem_addr` = `fpc`.
- IDLE → WAIT when `mem_req`=1.
- WAIT with `mem_rvalid`:
  - Push {`fpc`, `mem_rdata`}.
  - `fpc` ← `fpc`+`PC_STEP`, modulo 2^32 (wraps at 32'hFFFF_FFFC + 4 → 0).
  - Go to IDLE.
- FLUSH with `mem_rvalid`: discard the data, go to IDLE.
- `mem_rvalid` in IDLE is ignored.
- Overflow is impossible: issue requires count<DEPTH and only one request is outstanding.
- Pop when `inst_valid` && `inst_ready` && !`redirect`. Pointers advance modulo DEPTH.
- Simultaneous push and pop leaves count unchanged and preserves FIFO order.
- `inst_valid` = (count!=0).
- `inst_data` and `inst_pc` show the head entry when valid; both are 0 when `inst_valid`=0.
- `redirect` has highest priority and overrides push and pop in the same cycle:
  - Count and pointers ← 0.
  - `fpc` ← `redirect_pc`.
  - IDLE → IDLE. No request is issued that cycle.
  - WAIT without `mem_rvalid` → FLUSH.
  - WAIT with `mem_rvalid` → IDLE; the returned data is dropped.
  - FLUSH → FLUSH; `fpc` is updated to `redirect_pc`.
- Reset (any time, including mid-request):
  - State IDLE, count 0, pointers 0, `fpc`=`RESET_PC`.
  - `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `level`=0.
  - A response still in flight arrives in IDLE and is ignored.

## Timing

- First cycle after `rst` deasserts: `mem_req`=1, `mem_addr`=`RESET_PC`.
- Request at edge t, memory latency L≥1: `mem_rvalid` at cycle t+L.
  - Entry is visible at t+L+1 (`inst_valid`=1 if the FIFO was empty).
  - Next `mem_req` is at t+L+1.
- Throughput: one word per L+1 cycles.
- Full at cycle c with pop at c: `mem_req`=1 at c+1.
- `redirect` at cycle r:
  - `inst_valid`=0 at r+1.
  - From IDLE or WAIT+rvalid: `mem_req` with `redirect_pc` at r+1.
  - From WAIT without rvalid: `mem_req` the cycle after the stale `mem_rvalid`.

## Test plan

- Reset, L=1 memory returning `addr`^32'hA5A5_0000, `inst_ready`=1:
  - `mem_addr` sequence 0, 4, 8 on alternate cycles.
  - `inst_pc`/`inst_data` = 0/A5A5_0000, then 4/A5A5_0004, in order.
- `inst_ready`=0, L=1:
  - After 4 returns, `level`=4 and `mem_req` stays 0.
  - Pulse `inst_ready` for one cycle → `level`=3, `mem_req`=1 next cycle with `mem_addr`=16.
- L=3, `redirect` with `redirect_pc`=32'h100 one cycle after a request:
  - FSM goes to FLUSH and the stale word is dropped.
  - Next `mem_addr`=32'h100; first `inst_pc`=32'h100.
- `redirect`, `mem_rvalid` and pop in the same cycle at `level`=2:
  - Next cycle `level`=0, `inst_valid`=0, `mem_req`=1 with `redirect_pc`.
- Assert `rst` mid-WAIT, release, then deliver the stale `mem_rvalid`:
  - Response is ignored, `level` stays 0.
  - `mem_addr`=`RESET_PC` with `mem_req`=1.
- Steady state at `level`=2 with push and pop in the same cycle:
  - `level` stays 2 and `inst_pc` increments by 4 per pop.
